// File: rtl/mdio_pkg.sv
// -----------------------------------------------------------------------------
// mdio_pkg
// Shared constants for the Clause-22 MDIO master: frame field codes, field
// bit counts, FSM state encodings and a helper that packs the 32 bits
// following the preamble (ST, OP, PHYAD, REGAD, TA, DATA), MSB first.
// -----------------------------------------------------------------------------
package mdio_pkg;

    // Frame field codes
    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    // Field bit counts after the preamble
    localparam int HDR_BITS     = 14;
    localparam int TA_BITS      = 2;
    localparam int DATA_BITS    = 16;
    localparam int PAYLOAD_BITS = HDR_BITS + TA_BITS + DATA_BITS;

    // FSM state encodings
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_TA   = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;

    // Packs everything after the preamble. For reads the TA/DATA bits are
    // never driven (pad released), so their content is irrelevant.
    function automatic logic [31:0] build_payload(
        input logic        write,
        input logic [4:0]  phy_addr,
        input logic [4:0]  reg_addr,
        input logic [15:0] wdata
    );
        logic [1:0] op;
        op = write ? OP_WRITE : OP_READ;
        return {ST, op, phy_addr, reg_addr, TA_WRITE, wdata};
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// -----------------------------------------------------------------------------
// mdio_clk_gen
// MDC divider. While i_run is high, MDC is low for CLK_DIV cycles then high
// for CLK_DIV cycles. Held at 0 (divider cleared) when idle or on restart.
// Ports:
//   i_clk, i_rst     : system clock, synchronous active-high reset
//   i_restart        : clear divider (command acceptance)
//   i_run            : frame in progress
//   o_mdc            : management clock (registered)
//   o_rise           : MDC rises on the clock edge ending this cycle
//   o_bit_start      : a new bit begins on the clock edge ending this cycle
// -----------------------------------------------------------------------------
module mdio_clk_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    input  logic i_run,
    output logic o_mdc,
    output logic o_rise,
    output logic o_bit_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

    if (CLK_DIV < 2) begin : g_bad_div
        $error("mdio_clk_gen: CLK_DIV must be at least 2");
    end

    logic [DIV_W-1:0] r_div;
    logic             r_mdc;
    logic             w_wrap;

    assign w_wrap      = (r_div == DIV_LAST);
    assign o_mdc       = r_mdc;
    assign o_rise      = i_run && w_wrap && !r_mdc;
    assign o_bit_start = i_run && w_wrap && r_mdc;

    // Half-period counter; MDC toggles each time the counter wraps
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= DIV_ZERO;
            r_mdc <= 1'b0;
        end else if (i_restart || !i_run) begin
            r_div <= DIV_ZERO;
            r_mdc <= 1'b0;
        end else if (w_wrap) begin
            r_div <= DIV_ZERO;
            r_mdc <= ~r_mdc;
        end else begin
            r_div <= r_div + DIV_ONE;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// -----------------------------------------------------------------------------
// mdio_master
// Clause-22 MDIO management master. Accepts one read/write command over a
// valid/ready handshake, serialises preamble + 32-bit frame onto MDC/MDIO and
// returns a one-cycle response strobe at the end of every frame.
// Optional feature macro: MDIO_TA_CHECK_EN -- when defined, a read frame
// whose second turnaround bit is not 0 reports o_rsp_err with o_rsp_valid.
// Ports:
//   i_clk, i_rst          : system clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready: command handshake
//   i_cmd_write           : 1 = write, 0 = read
//   i_cmd_phy_addr/_reg_addr/_wdata : command fields
//   o_rsp_valid           : one-cycle end-of-frame pulse
//   o_rsp_rdata           : read data, held until the next read completes
//   o_rsp_err             : turnaround error, valid with o_rsp_valid
//   o_busy                : frame in progress
//   o_mdc, o_mdio_out, o_mdio_oen (1 = release), i_mdio_in : pad interface
// -----------------------------------------------------------------------------
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV      = 20,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [4:0]  i_cmd_phy_addr,
    input  logic [4:0]  i_cmd_reg_addr,
    input  logic [15:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_busy,
    output logic        o_mdc,
    input  logic        i_mdio_in,
    output logic        o_mdio_out,
    output logic        o_mdio_oen
);

    localparam int N_BITS = PREAMBLE_LEN + PAYLOAD_BITS;
    localparam logic [6:0] HDR_START  = 7'(PREAMBLE_LEN);
    localparam logic [6:0] TA_START   = 7'(PREAMBLE_LEN + HDR_BITS);
    localparam logic [6:0] DATA_START = 7'(PREAMBLE_LEN + HDR_BITS + TA_BITS);
    localparam logic [6:0] LAST_BIT   = 7'(N_BITS - 1);
`ifdef MDIO_TA_CHECK_EN
    localparam logic [6:0] TA2_BIT    = 7'(PREAMBLE_LEN + HDR_BITS + 1);
`endif

    // The 7-bit bit counter must hold every bit index of a frame
    if (PREAMBLE_LEN < 1 || N_BITS > 128) begin : g_bad_pre
        $error("mdio_master: PREAMBLE_LEN must be in 1..96");
    end

    logic [2:0]  r_state;
    logic [6:0]  r_bit_cnt;
    logic [31:0] r_shift;
    logic        r_write;
    logic [15:0] r_rx;
    logic        r_ta_err;
    logic        r_mdio_out;
    logic        r_mdio_oen;
    logic        r_busy;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_accept;
    logic        w_run;
    logic        w_rise;
    logic        w_bit_start;
    logic [6:0]  w_next_bit;
    logic [2:0]  w_next_state;

    assign o_cmd_ready = (r_state == S_IDLE) && !i_rst;
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_run       = (r_state != S_IDLE);
    assign w_next_bit  = r_bit_cnt + 7'd1;

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_busy      = r_busy;
    assign o_mdio_out  = r_mdio_out;
    assign o_mdio_oen  = r_mdio_oen;

    mdio_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_restart   (w_accept),
        .i_run       (w_run),
        .o_mdc       (o_mdc),
        .o_rise      (w_rise),
        .o_bit_start (w_bit_start)
    );

    // Frame field that the upcoming bit index falls into
    always_comb begin
        w_next_state = S_DATA;
        if (w_next_bit < HDR_START) begin
            w_next_state = S_PRE;
        end else if (w_next_bit < TA_START) begin
            w_next_state = S_HDR;
        end else if (w_next_bit < DATA_START) begin
            w_next_state = S_TA;
        end else begin
            w_next_state = S_DATA;
        end
    end

    // Frame sequencer: accept, shift out bits at bit starts, sample at MDC rise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 7'd0;
            r_shift     <= 32'd0;
            r_write     <= 1'b0;
            r_rx        <= 16'd0;
            r_ta_err    <= 1'b0;
            r_mdio_out  <= 1'b1;
            r_mdio_oen  <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                // Bit 0 (first preamble '1') starts in the next cycle
                r_state    <= S_PRE;
                r_bit_cnt  <= 7'd0;
                r_shift    <= build_payload(i_cmd_write, i_cmd_phy_addr,
                                            i_cmd_reg_addr, i_cmd_wdata);
                r_write    <= i_cmd_write;
                r_rx       <= 16'd0;
                r_ta_err   <= 1'b0;
                r_busy     <= 1'b1;
                r_mdio_out <= 1'b1;
                r_mdio_oen <= 1'b0;
            end else if (r_state != S_IDLE) begin
                if (w_rise && !r_write) begin
                    if (r_state == S_DATA) begin
                        r_rx <= {r_rx[14:0], i_mdio_in};
                    end
`ifdef MDIO_TA_CHECK_EN
                    // A PHY that answers pulls the second TA bit low
                    if (r_bit_cnt == TA2_BIT) begin
                        r_ta_err <= i_mdio_in;
                    end
`endif
                end
                if (w_bit_start) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_mdio_out  <= 1'b1;
                        r_mdio_oen  <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        if (!r_write) begin
                            r_rsp_rdata <= r_rx;
                            r_rsp_err   <= r_ta_err;
                        end else begin
                            r_rsp_err   <= 1'b0;
                        end
                    end else begin
                        r_bit_cnt <= w_next_bit;
                        r_state   <= w_next_state;
                        if (w_next_bit >= HDR_START) begin
                            r_mdio_out <= r_shift[31];
                            r_shift    <= {r_shift[30:0], 1'b0};
                        end else begin
                            r_mdio_out <= 1'b1;
                        end
                        // Reads hand the pad to the PHY from the first TA bit
                        r_mdio_oen <= !r_write && (w_next_bit >= TA_START);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
module tb_mdio_master;

    localparam int D       = 2;
    localparam int NB      = 64;
    localparam int FRAME_T = 1 + 2 * NB * D;   // 257: rsp_valid cycle

`ifdef MDIO_TA_CHECK_EN
    localparam logic EXP_TA_ERR = 1'b1;
`else
    localparam logic EXP_TA_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [4:0]  i_cmd_phy_addr;
    logic [4:0]  i_cmd_reg_addr;
    logic [15:0] i_cmd_wdata;
    logic        o_rsp_valid;
    logic [15:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_busy;
    logic        o_mdc;
    logic        i_mdio_in;
    logic        o_mdio_out;
    logic        o_mdio_oen;

    int checks = 0;
    int errors = 0;

    // PHY-side bit per frame position, bit k stored at [63-k]
    logic [63:0] phy_bits;

    // Frame observations gathered by run_frame
    logic [63:0] cap_out;
    logic [63:0] cap_oen;
    int          rsp_t;
    int          rsp_cnt;
    int          mdc_bad;
    int          busy_bad;
    int          chg_bad;
    logic [15:0] rsp_rdata_s;
    logic        rsp_err_s;
    logic        ready_at_rsp;

    always #5 clk = ~clk;

    mdio_master #(
        .CLK_DIV      (D),
        .PREAMBLE_LEN (32)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_write    (i_cmd_write),
        .i_cmd_phy_addr (i_cmd_phy_addr),
        .i_cmd_reg_addr (i_cmd_reg_addr),
        .i_cmd_wdata    (i_cmd_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_busy         (o_busy),
        .o_mdc          (o_mdc),
        .i_mdio_in      (i_mdio_in),
        .o_mdio_out     (o_mdio_out),
        .o_mdio_oen     (o_mdio_oen)
    );

    // Present a command on the falling edge; acceptance happens at the next rise
    task automatic issue(input logic w, input logic [4:0] p, input logic [4:0] r,
                         input logic [15:0] d);
        @(negedge clk);
        i_cmd_write    = w;
        i_cmd_phy_addr = p;
        i_cmd_reg_addr = r;
        i_cmd_wdata    = d;
        i_cmd_valid    = 1'b1;
    endtask

    // Observe one frame cycle by cycle (called just after the acceptance edge),
    // playing the PHY from phy_bits and recording pin behaviour.
    task automatic run_frame(input bit stop_at_rsp);
        logic prev_out;
        logic prev_oen;
        cap_out = 64'd0; cap_oen = 64'd0;
        rsp_t = -1; rsp_cnt = 0; mdc_bad = 0; busy_bad = 0; chg_bad = 0;
        ready_at_rsp = 1'b0; rsp_rdata_s = 16'd0; rsp_err_s = 1'b0;
        prev_out = 1'b1; prev_oen = 1'b1;
        for (int t = 1; t <= FRAME_T + 2; t++) begin
            int k;
            int ph;
            @(negedge clk);
            k  = (t - 1) / (2 * D);
            ph = (t - 1) % (2 * D);
            if (k < NB) begin
                i_mdio_in = phy_bits[63 - k];
                if (ph == D) begin
                    cap_out[63 - k] = o_mdio_out;
                    cap_oen[63 - k] = o_mdio_oen;
                end
                if (ph != 0 && (o_mdio_out !== prev_out || o_mdio_oen !== prev_oen))
                    chg_bad++;
            end else begin
                i_mdio_in = 1'b1;
            end
            prev_out = o_mdio_out;
            prev_oen = o_mdio_oen;
            if (o_mdc !== ((k < NB) && (ph >= D))) mdc_bad++;
            if (o_busy !== (k < NB)) busy_bad++;
            if (o_rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (rsp_t < 0) begin
                    rsp_t        = t;
                    rsp_rdata_s  = o_rsp_rdata;
                    rsp_err_s    = o_rsp_err;
                    ready_at_rsp = o_cmd_ready;
                end
            end
            if (stop_at_rsp && rsp_t > 0) break;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0;
        i_cmd_phy_addr = 5'd0; i_cmd_reg_addr = 5'd0; i_cmd_wdata = 16'd0;
        i_mdio_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_mdc, o_mdio_out, o_mdio_oen, o_rsp_valid, o_rsp_err, o_busy, o_cmd_ready} !== 7'b0110000) begin
            errors++;
            $display("FAIL reset_pins: got mdc/out/oen/rv/err/busy/rdy=%b expected 0110000",
                     {o_mdc, o_mdio_out, o_mdio_oen, o_rsp_valid, o_rsp_err, o_busy, o_cmd_ready});
        end
        checks++;
        if (o_rsp_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0000", o_rsp_rdata);
        end
        i_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", o_cmd_ready);
        end
    endtask

    task automatic test_write();
        phy_bits = {64{1'b1}};
        issue(1'b1, 5'd1, 5'd0, 16'h1140);
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        run_frame(1'b0);
        checks++;
        if (cap_out !== 64'hFFFF_FFFF_5082_1140) begin
            errors++;
            $display("FAIL write_bits: got %h expected ffffffff50821140", cap_out);
        end
        checks++;
        if (cap_oen !== 64'd0) begin
            errors++;
            $display("FAIL write_oen: got %h expected 0", cap_oen);
        end
        checks++;
        if (rsp_t !== FRAME_T || rsp_cnt !== 1) begin
            errors++;
            $display("FAIL write_rsp_time: got t=%0d n=%0d expected t=%0d n=1", rsp_t, rsp_cnt, FRAME_T);
        end
        checks++;
        if (mdc_bad !== 0 || busy_bad !== 0 || chg_bad !== 0) begin
            errors++;
            $display("FAIL write_timing: got mdc=%0d busy=%0d chg=%0d bad cycles expected 0",
                     mdc_bad, busy_bad, chg_bad);
        end
        checks++;
        if (rsp_rdata_s !== 16'h0000 || rsp_err_s !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp: got rdata=%h err=%b expected 0000/0", rsp_rdata_s, rsp_err_s);
        end
        checks++;
        if ({o_mdio_out, o_mdio_oen, o_cmd_ready} !== 3'b111) begin
            errors++;
            $display("FAIL write_idle: got out/oen/rdy=%b expected 111", {o_mdio_out, o_mdio_oen, o_cmd_ready});
        end
    endtask

    task automatic test_read();
        // TA bit 1 released (pull-up), TA bit 2 driven 0, then 0x0141
        phy_bits = {{46{1'b1}}, 1'b1, 1'b0, 16'h0141};
        issue(1'b0, 5'd1, 5'd2, 16'h0000);
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        run_frame(1'b0);
        checks++;
        if (cap_out[63:18] !== {32'hFFFF_FFFF, 14'h1822}) begin
            errors++;
            $display("FAIL read_hdr: got %h expected %h", cap_out[63:18], {32'hFFFF_FFFF, 14'h1822});
        end
        checks++;
        if (cap_oen !== 64'h0000_0000_0003_FFFF) begin
            errors++;
            $display("FAIL read_oen: got %h expected 000000000003ffff", cap_oen);
        end
        checks++;
        if (rsp_t !== FRAME_T || rsp_rdata_s !== 16'h0141 || rsp_err_s !== 1'b0) begin
            errors++;
            $display("FAIL read_rsp: got t=%0d rdata=%h err=%b expected t=%0d rdata=0141 err=0",
                     rsp_t, rsp_rdata_s, rsp_err_s, FRAME_T);
        end
        checks++;
        if (mdc_bad !== 0 || busy_bad !== 0) begin
            errors++;
            $display("FAIL read_timing: got mdc=%0d busy=%0d bad cycles expected 0", mdc_bad, busy_bad);
        end
    endtask

    task automatic test_back_to_back();
        phy_bits = {64{1'b1}};
        issue(1'b1, 5'd3, 5'd4, 16'h1234);
        @(posedge clk);
        // Keep valid high; fields change mid-frame and become the second command
        #1;
        i_cmd_phy_addr = 5'd31;
        i_cmd_reg_addr = 5'd31;
        i_cmd_wdata    = 16'hA5A5;
        run_frame(1'b1);
        checks++;
        if (cap_out !== 64'hFFFF_FFFF_5192_1234) begin
            errors++;
            $display("FAIL latched_wdata: got %h expected ffffffff51921234", cap_out);
        end
        checks++;
        if (rsp_t !== FRAME_T || ready_at_rsp !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_rsp: got t=%0d ready=%b expected t=%0d ready=1", rsp_t, ready_at_rsp, FRAME_T);
        end
        checks++;
        if (rsp_rdata_s !== 16'h0141) begin
            errors++;
            $display("FAIL write_keeps_rdata: got %h expected 0141", rsp_rdata_s);
        end
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        run_frame(1'b0);
        checks++;
        if (cap_out !== 64'hFFFF_FFFF_5FFE_A5A5) begin
            errors++;
            $display("FAIL b2b_second_bits: got %h expected ffffffff5ffea5a5", cap_out);
        end
        checks++;
        if (rsp_t !== FRAME_T || busy_bad !== 0 || mdc_bad !== 0) begin
            errors++;
            $display("FAIL b2b_second_timing: got t=%0d busy_bad=%0d mdc_bad=%0d expected t=%0d 0 0",
                     rsp_t, busy_bad, mdc_bad, FRAME_T);
        end
    endtask

    task automatic test_ta_check();
        // PHY never answers: pad stays pulled high through TA and DATA
        phy_bits = {64{1'b1}};
        issue(1'b0, 5'd7, 5'd9, 16'h0000);
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        run_frame(1'b0);
        checks++;
        if (rsp_t !== FRAME_T || rsp_rdata_s !== 16'hFFFF) begin
            errors++;
            $display("FAIL ta_rdata: got t=%0d rdata=%h expected t=%0d rdata=ffff", rsp_t, rsp_rdata_s, FRAME_T);
        end
        checks++;
        if (rsp_err_s !== EXP_TA_ERR) begin
            errors++;
            $display("FAIL ta_err: got %b expected %b", rsp_err_s, EXP_TA_ERR);
        end
    endtask

    task automatic test_rst_midframe();
        int n_rsp;
        n_rsp = 0;
        issue(1'b1, 5'd1, 5'd0, 16'h1140);
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        // Bit 40 spans cycles 161..164; assert rst in cycle 163 while MDC is high
        for (int t = 1; t <= 163; t++) begin
            @(negedge clk);
            if (o_rsp_valid === 1'b1) n_rsp++;
        end
        i_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_mdio_oen, o_mdio_out, o_mdc, o_busy, o_rsp_valid, o_cmd_ready} !== 6'b110000) begin
            errors++;
            $display("FAIL rst_abort: got oen/out/mdc/busy/rv/rdy=%b expected 110000",
                     {o_mdio_oen, o_mdio_out, o_mdc, o_busy, o_rsp_valid, o_cmd_ready});
        end
        i_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: got %b expected 1", o_cmd_ready);
        end
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (o_rsp_valid === 1'b1 || o_busy === 1'b1) n_rsp++;
        end
        checks++;
        if (n_rsp !== 0) begin
            errors++;
            $display("FAIL rst_no_rsp: got %0d rsp/busy cycles expected 0", n_rsp);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_ta_check();
        test_rst_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
